// File: rtl/axi_aw_arbiter.sv
// Round-robin arbiter merging several AXI write-address channels onto one slave port.
// A small FIFO records the winning master of each address so the W channel can be routed.
module axi_aw_arbiter #(
   parameter int NUM_M      = 2,
   parameter int ID_BITS    = 4,
   parameter int ADDR_BITS  = 32,
   parameter int LEN_BITS   = 4,
   parameter int SIZE_BITS  = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [NUM_M*ID_BITS-1:0]      AWID_M,
   input  logic [NUM_M*ADDR_BITS-1:0]    AWADDR_M,
   input  logic [NUM_M*LEN_BITS-1:0]     AWLEN_M,
   input  logic [NUM_M*SIZE_BITS-1:0]    AWSIZE_M,
   input  logic [NUM_M*2-1:0]            AWBURST_M,
   input  logic [NUM_M-1:0]              AWVALID_M,
   output logic [NUM_M-1:0]              AWREADY_M,
   output logic [ID_BITS+3:0]            AWID_S,
   output logic [ADDR_BITS-1:0]          AWADDR_S,
   output logic [LEN_BITS-1:0]           AWLEN_S,
   output logic [SIZE_BITS-1:0]          AWSIZE_S,
   output logic [1:0]                    AWBURST_S,
   output logic                          AWVALID_S,
   input  logic                          AWREADY_S,
   input  logic                          WLAST_HS,
   output logic [3:0]                    WSEL,
   output logic                          WSEL_VALID
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int FPTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t              state;
   logic [3:0]          ptr;
   logic [3:0]          fifo_mem [FIFO_DEPTH];
   logic [FPTR_W-1:0]   rd_ptr;
   logic [FPTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]    count;
   logic                full;
   logic                accept;
   logic                pop;
   logic                hi_found;
   logic                lo_found;
   logic [3:0]          hi_grant;
   logic [3:0]          lo_grant;
   logic [3:0]          grant;
   logic [ID_BITS-1:0]  sel_id;
   logic [ADDR_BITS-1:0] sel_addr;
   logic [LEN_BITS-1:0] sel_len;
   logic [SIZE_BITS-1:0] sel_size;
   logic [1:0]          sel_burst;

   // Lowest valid index at or above the pointer wins; otherwise wrap to the lowest below it.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_grant = '0;
      lo_grant = '0;
      for (int i = NUM_M - 1; i >= 0; i--) begin
         if (AWVALID_M[i] && (4'(i) >= ptr)) begin
            hi_found = 1'b1;
            hi_grant = 4'(i);
         end
         if (AWVALID_M[i] && (4'(i) < ptr)) begin
            lo_found = 1'b1;
            lo_grant = 4'(i);
         end
      end
      grant = hi_found ? hi_grant : lo_grant;
   end

   always_comb begin
      sel_id    = '0;
      sel_addr  = '0;
      sel_len   = '0;
      sel_size  = '0;
      sel_burst = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (grant == 4'(i)) begin
            sel_id    = AWID_M[i*ID_BITS +: ID_BITS];
            sel_addr  = AWADDR_M[i*ADDR_BITS +: ADDR_BITS];
            sel_len   = AWLEN_M[i*LEN_BITS +: LEN_BITS];
            sel_size  = AWSIZE_M[i*SIZE_BITS +: SIZE_BITS];
            sel_burst = AWBURST_M[i*2 +: 2];
         end
      end
   end

   // Full comes from the registered count, so a same-cycle pop never frees a slot early.
   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign accept    = !ARESET && (state == IDLE) && (|AWVALID_M) && !full;
   assign pop       = WLAST_HS && (count != '0);
   assign AWREADY_M = accept ? (NUM_M'(1) << grant) : '0;
   assign WSEL       = fifo_mem[rd_ptr];
   assign WSEL_VALID = (count != '0);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state     <= IDLE;
         ptr       <= '0;
         AWVALID_S <= 1'b0;
         AWID_S    <= '0;
         AWADDR_S  <= '0;
         AWLEN_S   <= '0;
         AWSIZE_S  <= '0;
         AWBURST_S <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  AWID_S    <= {grant, sel_id};
                  AWADDR_S  <= sel_addr;
                  AWLEN_S   <= sel_len;
                  AWSIZE_S  <= sel_size;
                  AWBURST_S <= sel_burst;
                  AWVALID_S <= 1'b1;
                  ptr       <= (grant == 4'(NUM_M - 1)) ? 4'd0 : grant + 4'd1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (AWREADY_S) begin
                  AWVALID_S <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         if (accept) begin
            fifo_mem[wr_ptr] <= grant;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_aw_arbiter.sv
// Directed bench for axi_aw_arbiter: a cycle-by-cycle vector table plus a reset-in-HOLD sequence.
module tb_axi_aw_arbiter;

   localparam int NUM_M      = 2;
   localparam int ID_BITS    = 4;
   localparam int ADDR_BITS  = 32;
   localparam int LEN_BITS   = 4;
   localparam int SIZE_BITS  = 3;
   localparam int FIFO_DEPTH = 4;

   logic                       ACLK = 1'b0;
   logic                       ARESET;
   logic [NUM_M*ID_BITS-1:0]   AWID_M;
   logic [NUM_M*ADDR_BITS-1:0] AWADDR_M;
   logic [NUM_M*LEN_BITS-1:0]  AWLEN_M;
   logic [NUM_M*SIZE_BITS-1:0] AWSIZE_M;
   logic [NUM_M*2-1:0]         AWBURST_M;
   logic [NUM_M-1:0]           AWVALID_M;
   logic [NUM_M-1:0]           AWREADY_M;
   logic [ID_BITS+3:0]         AWID_S;
   logic [ADDR_BITS-1:0]       AWADDR_S;
   logic [LEN_BITS-1:0]        AWLEN_S;
   logic [SIZE_BITS-1:0]       AWSIZE_S;
   logic [1:0]                 AWBURST_S;
   logic                       AWVALID_S;
   logic                       AWREADY_S;
   logic                       WLAST_HS;
   logic [3:0]                 WSEL;
   logic                       WSEL_VALID;

   always #5 ACLK = ~ACLK;

   axi_aw_arbiter #(
      .NUM_M(NUM_M), .ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS),
      .LEN_BITS(LEN_BITS), .SIZE_BITS(SIZE_BITS), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M),
      .AWSIZE_M(AWSIZE_M), .AWBURST_M(AWBURST_M),
      .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
      .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
      .AWSIZE_S(AWSIZE_S), .AWBURST_S(AWBURST_S),
      .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
      .WLAST_HS(WLAST_HS), .WSEL(WSEL), .WSEL_VALID(WSEL_VALID)
   );

   typedef struct {
      logic [1:0] valid;
      logic       rdy;
      logic       wl;
      logic [1:0] exp_rdy_m;
      logic       exp_v;
      logic [7:0] exp_id;
      logic [3:0] exp_wsel;
      logic       exp_wv;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   // Fixed per-master fields: M0 id 5 / 0x2000 / len 1, M1 id 3 / 0x1000 / len 3.
   function automatic logic [31:0] expAddr(input logic [3:0] m);
      return (m == 4'd1) ? 32'h1000 : 32'h2000;
   endfunction

   function automatic logic [3:0] expLen(input logic [3:0] m);
      return (m == 4'd1) ? 4'd3 : 4'd1;
   endfunction

   function automatic void addVec(input logic [1:0] valid, input logic rdy, input logic wl,
                                  input logic [1:0] erm, input logic ev, input logic [7:0] eid,
                                  input logic [3:0] ews, input logic ewv);
      vec_t v;
      v.valid = valid; v.rdy = rdy; v.wl = wl;
      v.exp_rdy_m = erm; v.exp_v = ev; v.exp_id = eid; v.exp_wsel = ews; v.exp_wv = ewv;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input logic [1:0] valid, input logic rdy, input logic wl);
      AWVALID_M = valid;
      AWREADY_S = rdy;
      WLAST_HS  = wl;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      AWID_M    = {4'h3, 4'h5};
      AWADDR_M  = {32'h1000, 32'h2000};
      AWLEN_M   = {4'd3, 4'd1};
      AWSIZE_M  = {3'd3, 3'd2};
      AWBURST_M = {2'b10, 2'b01};
      ARESET    = 1'b1;
      applyStimulus(2'b11, 1'b1, 1'b1);

      //      valid  rdy   wl    rdy_m  v     id     wsel  wv
      addVec(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0);
      addVec(2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0);
      addVec(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0);
      addVec(2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 8'h00, 4'd0, 1'b0);
      addVec(2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 8'h13, 4'd1, 1'b1);
      addVec(2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 4'd1, 1'b1);
      addVec(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0);
      addVec(2'b11, 1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 4'd0, 1'b0);
      addVec(2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 8'h05, 4'd0, 1'b1);
      addVec(2'b11, 1'b1, 1'b0, 2'b10, 1'b0, 8'h00, 4'd0, 1'b1);
      addVec(2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 8'h13, 4'd0, 1'b1);
      addVec(2'b11, 1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 4'd0, 1'b1);
      addVec(2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 8'h05, 4'd0, 1'b1);
      addVec(2'b11, 1'b1, 1'b0, 2'b10, 1'b0, 8'h00, 4'd0, 1'b1);
      addVec(2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 8'h13, 4'd0, 1'b1);
      addVec(2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 4'd0, 1'b1);
      addVec(2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 4'd0, 1'b1);
      addVec(2'b11, 1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 4'd1, 1'b1);
      addVec(2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 8'h05, 4'd1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         addVec(2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 8'h05, 4'd1, 1'b1);
      end
      addVec(2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 8'h05, 4'd1, 1'b1);
      addVec(2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 4'd1, 1'b1);
      addVec(2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 4'd0, 1'b1);
      addVec(2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 4'd1, 1'b1);
      addVec(2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 4'd0, 1'b1);
      addVec(2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 4'd0, 1'b0);
      addVec(2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 8'h05, 4'd0, 1'b1);
      addVec(2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 8'h00, 4'd0, 1'b0);
      addVec(2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 8'h13, 4'd1, 1'b1);
      addVec(2'b01, 1'b1, 1'b1, 2'b01, 1'b0, 8'h00, 4'd1, 1'b1);
      addVec(2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 8'h05, 4'd0, 1'b1);
      addVec(2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 4'd0, 1'b1);
      addVec(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0);

      // Outputs held at zero while reset is asserted, even with masters requesting.
      repeat (2) @(negedge ACLK);
      #1;
      checkOutput("rst awready_m", 32'(AWREADY_M), 32'h0);
      checkOutput("rst awvalid_s", 32'(AWVALID_S), 32'h0);
      checkOutput("rst awid_s", 32'(AWID_S), 32'h0);
      checkOutput("rst awaddr_s", AWADDR_S, 32'h0);
      checkOutput("rst wsel", 32'(WSEL), 32'h0);
      checkOutput("rst wsel_valid", 32'(WSEL_VALID), 32'h0);
      applyStimulus(2'b00, 1'b1, 1'b0);

      @(negedge ACLK);
      ARESET = 1'b0;
      foreach (vecs[i]) begin
         if (i != 0) @(negedge ACLK);
         applyStimulus(vecs[i].valid, vecs[i].rdy, vecs[i].wl);
         #1;
         checkOutput($sformatf("v%0d awready_m", i), 32'(AWREADY_M), 32'(vecs[i].exp_rdy_m));
         checkOutput($sformatf("v%0d awvalid_s", i), 32'(AWVALID_S), 32'(vecs[i].exp_v));
         checkOutput($sformatf("v%0d wsel_valid", i), 32'(WSEL_VALID), 32'(vecs[i].exp_wv));
         if (vecs[i].exp_v) begin
            checkOutput($sformatf("v%0d awid_s", i), 32'(AWID_S), 32'(vecs[i].exp_id));
            checkOutput($sformatf("v%0d awaddr_s", i), AWADDR_S, expAddr(vecs[i].exp_id[7:4]));
            checkOutput($sformatf("v%0d awlen_s", i), 32'(AWLEN_S), 32'(expLen(vecs[i].exp_id[7:4])));
         end
         if (vecs[i].exp_wv) begin
            checkOutput($sformatf("v%0d wsel", i), 32'(WSEL), 32'(vecs[i].exp_wsel));
         end
      end

      // Reset while holding an address with two routing entries queued.
      @(negedge ACLK);
      applyStimulus(2'b01, 1'b1, 1'b0);
      @(negedge ACLK);
      applyStimulus(2'b00, 1'b1, 1'b0);
      @(negedge ACLK);
      applyStimulus(2'b10, 1'b0, 1'b0);
      @(negedge ACLK);
      applyStimulus(2'b00, 1'b0, 1'b0);
      #1;
      checkOutput("pre-rst awvalid_s", 32'(AWVALID_S), 32'h1);
      checkOutput("pre-rst awid_s", 32'(AWID_S), 32'h13);
      checkOutput("pre-rst wsel", 32'(WSEL), 32'h0);
      #1;
      ARESET = 1'b1;
      #1;
      checkOutput("mid-rst awvalid_s", 32'(AWVALID_S), 32'h0);
      checkOutput("mid-rst wsel_valid", 32'(WSEL_VALID), 32'h0);
      checkOutput("mid-rst awid_s", 32'(AWID_S), 32'h0);
      @(negedge ACLK);
      ARESET = 1'b0;
      applyStimulus(2'b11, 1'b1, 1'b0);
      #1;
      checkOutput("post-rst awready_m", 32'(AWREADY_M), 32'h1);
      checkOutput("post-rst awvalid_s", 32'(AWVALID_S), 32'h0);
      checkOutput("post-rst wsel_valid", 32'(WSEL_VALID), 32'h0);
      @(negedge ACLK);
      applyStimulus(2'b00, 1'b1, 1'b0);
      #1;
      checkOutput("post-rst awid_s", 32'(AWID_S), 32'h05);
      checkOutput("post-rst wsel", 32'(WSEL), 32'h0);
      checkOutput("post-rst wsel_valid2", 32'(WSEL_VALID), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_aw_arbiter.md
AXI_AW_ARBITER -- requirements
Module: axi_aw_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_M, default 2: number of masters, legal range 2..16.
REQ-002 The block SHALL have parameter ID_BITS, default 4: master-side AWID width.
REQ-003 The block SHALL have parameter ADDR_BITS, default 32: AWADDR width.
REQ-004 The block SHALL have parameter LEN_BITS, default 4: AWLEN width.
REQ-005 The block SHALL have parameter SIZE_BITS, default 3: AWSIZE width.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 4: write-route FIFO depth, power of 2, at least 2.
Ports (name, direction, width, meaning):
REQ-007 The block SHALL have port ACLK, in, 1: the single clock; all state changes on the rising edge.
REQ-008 The block SHALL have port ARESET, in, 1: asynchronous, active-high reset.
REQ-009 The block SHALL have port AWID_M, in, NUM_M*ID_BITS: packed master IDs, master i at slice i.
REQ-010 The block SHALL have ports AWADDR_M, AWLEN_M, AWSIZE_M and AWBURST_M, in, NUM_M times the field width each: packed per master.
REQ-011 The block SHALL have ports AWVALID_M, in, NUM_M, and AWREADY_M, out, NUM_M: per-master handshake.
REQ-012 The block SHALL have port AWID_S, out, ID_BITS+4: master index zero-extended to 4 bits, concatenated above the master ID.
REQ-013 The block SHALL have ports AWADDR_S, AWLEN_S, AWSIZE_S and AWBURST_S, out, field widths: slave-side fields.
REQ-014 The block SHALL have ports AWVALID_S, out, 1, and AWREADY_S, in, 1: slave-side handshake.
REQ-015 The block SHALL have port WLAST_HS, in, 1: pulse on a W-channel beat with WLAST&WVALID&WREADY.
REQ-016 The block SHALL have ports WSEL, out, 4, and WSEL_VALID, out, 1: master index owning the current write-data burst.

Function
REQ-017 The state machine SHALL have two states: IDLE (output slot empty) and HOLD (output slot full).
REQ-018 In IDLE with any AWVALID_M[i] high and the FIFO not full, the block SHALL grant exactly one master using round-robin.
- Priority starts at the pointer and proceeds upward with wrap.
REQ-019 The grant SHALL be combinational; AWREADY_M[g] SHALL be high for that single cycle, and all other AWREADY_M bits SHALL be low.
REQ-020 On acceptance, the block SHALL register master g's fields into the output slot and set AWID_S to {g[3:0], AWID_M slice g}.
- Also on acceptance: push g into the FIFO, set the pointer to (g+1) mod NUM_M, and go to HOLD.
REQ-021 In HOLD, AWVALID_S SHALL be 1 and all output fields SHALL stay stable until AWREADY_S is sampled high.
- On that edge the block SHALL return to IDLE.
- Latency is one cycle from master acceptance to AWVALID_S.
- Throughput is at most one address per two cycles.
REQ-022 In HOLD, every AWREADY_M bit SHALL be 0; master requests stay pending.
REQ-023 In IDLE, AWVALID_S SHALL be 0 and AWREADY_M SHALL be all zero when no master is valid or the FIFO is full.
REQ-024 The FIFO SHALL hold master indices in AW acceptance order.
- WSEL = head entry; WSEL_VALID = not empty.
- The count is clog2(FIFO_DEPTH)+1 bits wide.
- Read and write pointers wrap modulo FIFO_DEPTH.
REQ-025 On WLAST_HS with the FIFO non-empty, the block SHALL pop the head; WLAST_HS with the FIFO empty SHALL be ignored with no state change.
REQ-026 A simultaneous push and pop SHALL leave the count unchanged.
REQ-027 Full SHALL be evaluated from the registered count, so a pop in the same cycle does not admit a push when full.
REQ-028 The round-robin pointer SHALL change only on acceptance.
REQ-029 Pointer values of NUM_M or above are unreachable and SHALL NOT occur.

Reset
REQ-030 While ARESET is high, the block SHALL asynchronously force:
- state IDLE and pointer 0
- FIFO count and pointers 0
- AWVALID_S=0, WSEL_VALID=0, AWREADY_M all zero
- AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S and WSEL all zero
REQ-031 A reset asserted during HOLD or with the FIFO non-empty SHALL discard the pending address and all routing entries.
- No AWVALID_S SHALL appear after release until a new acceptance.
REQ-032 On the first edge after reset deassertion, the block SHALL start from IDLE with master 0 at highest priority.

Verification
REQ-033 Single request: M1 valid with ID=0x3, ADDR=0x1000, LEN=3 and AWREADY_S=1 -> AWREADY_M=2'b10 for one cycle; next cycle AWVALID_S=1 and AWID_S=0x13; WSEL=1 and WSEL_VALID=1.
REQ-034 Contention: M0 and M1 valid continuously, AWREADY_S=1 -> grants alternate M0, M1, M0, M1, with AWID_S upper nibble 0,1,0,1.
REQ-035 Backpressure: AWREADY_S=0 for 5 cycles during HOLD -> AWVALID_S stays 1 with fields stable, AWREADY_M=0 throughout; accept on cycle 6, then IDLE.
REQ-036 FIFO full: 4 accepted addresses with no WLAST_HS -> 5th request not granted; WLAST_HS and request in the same cycle -> no grant that cycle, grant next cycle; WSEL order matches acceptance order.
REQ-037 Reset mid-operation: ARESET pulsed while in HOLD with 2 FIFO entries -> AWVALID_S=0 and WSEL_VALID=0 immediately; after release, M0 wins over simultaneous M1.
REQ-038 Spurious pop: WLAST_HS with FIFO empty -> count stays 0, WSEL_VALID stays 0.
